// File: rtl/freq_gate_controller.sv
// Gated edge counter: sync IN, count rising edges over GATE_CYCLES, hand off result.
// Define FREQ_SAT_EN to saturate the counter instead of wrapping.
module freq_gate_controller #(
   parameter int unsigned GATE_CYCLES = 100_000_000,
   parameter int          CNT_W       = 12
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN,
   input  logic             EN,
   input  logic             ready,
   output logic [CNT_W-1:0] bnum,
   output logic             valid,
   output logic             OVF,
   output logic             GATE
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_COUNT,
      S_LATCH,
      S_HOLD
   } state_t;

   localparam logic [31:0]      LAST_T = 32'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_C  = '1;

   state_t           r_state;
   state_t           w_next;
   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic [31:0]      r_timer;
   logic [CNT_W-1:0] r_bnum;
   logic             r_valid;
   logic             r_ovf_out;
   logic             w_edge;
   logic             w_last;

   assign w_edge = r_s2 & ~r_s3;
   assign w_last = (r_timer == LAST_T);

   assign bnum  = r_bnum;
   assign valid = r_valid;
   assign OVF   = r_ovf_out;
   assign GATE  = (r_state == S_COUNT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (EN) w_next = S_ARM;
         S_ARM:   w_next = EN ? S_COUNT : S_IDLE;
         S_COUNT: begin
            if (!EN)
               w_next = S_IDLE;
            else if (w_last)
               w_next = S_LATCH;
         end
         S_LATCH: w_next = S_HOLD;
         S_HOLD: begin
            if (r_valid && ready)
               w_next = EN ? S_ARM : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_s3      <= 1'b0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_timer   <= '0;
         r_bnum    <= '0;
         r_valid   <= 1'b0;
         r_ovf_out <= 1'b0;
      end else begin
         r_s1 <= IN;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         unique case (r_state)
            S_IDLE: begin
               r_cnt   <= '0;
               r_timer <= '0;
            end
            S_ARM: begin
               r_cnt   <= '0;
               r_ovf   <= 1'b0;
               r_timer <= '0;
            end
            S_COUNT: begin
               r_timer <= r_timer + 32'd1;
               if (w_edge) begin
                  if (r_cnt == MAX_C) begin
                     r_ovf <= 1'b1;
`ifdef FREQ_SAT_EN
                     r_cnt <= r_cnt;
`else
                     r_cnt <= '0;
`endif
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_LATCH: begin
               r_bnum    <= r_cnt;
               r_ovf_out <= r_ovf;
               r_valid   <= 1'b1;
            end
            S_HOLD: begin
               if (r_valid && ready)
                  r_valid <= 1'b0;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_gate_controller.sv
// Bench for freq_gate_controller: random/periodic IN against an edge-history model.
// Expected counts come from the recorded IN samples over each gate window.
module tb_freq_gate_controller;

   localparam int G    = 200;
   localparam int W    = 6;
   localparam int MAXV = (1 << W) - 1;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         IN = 1'b0;
   logic         EN = 1'b0;
   logic         ready = 1'b0;
   logic [W-1:0] bnum;
   logic         valid;
   logic         OVF;
   logic         GATE;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit in_hist [0:32767];
   int mode = 0;
   int per = 10;
   int pc = 0;
   logic hold_v = 1'b0;
   int last_b = 0;
   int last_o = 0;

   always #5 CLK = ~CLK;

   freq_gate_controller #(
      .GATE_CYCLES(G),
      .CNT_W      (W)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .IN   (IN),
      .EN   (EN),
      .ready(ready),
      .bnum (bnum),
      .valid(valid),
      .OVF  (OVF),
      .GATE (GATE)
   );

   // What the first sync flop captured at each edge (reset clears it).
   always @(posedge CLK) begin
      in_hist[cyc] <= RST ? 1'b0 : IN;
      cyc <= cyc + 1;
   end

   always @(negedge CLK) begin
      case (mode)
         1: begin
            IN = ((pc % per) >= (per / 2));
            pc++;
         end
         2: IN = 1'($urandom_range(0, 1));
         default: IN = hold_v;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   // Gate window occupies intervals a+1..a+G; interval m sees the rise
   // between the samples taken two and three edges earlier.
   task automatic expect_of(input int a, output int eb, output int eo);
      int n = 0;
      for (int m = a + 1; m <= a + G; m++)
         n += int'(in_hist[m-1] & ~in_hist[m-2]);
      eo = (n > MAXV) ? 1 : 0;
`ifdef FREQ_SAT_EN
      eb = eo ? MAXV : n;
`else
      eb = n % (MAXV + 1);
`endif
   endtask

   task automatic measure(input bit armed, input int hold_wait,
                          input bit keep_en);
      int a;
      int eb;
      int eo;
      if (!armed) begin
         EN = 1'b1;
         chk("idle_gate", 32'(GATE), 0);
         tick();
      end
      a = cyc - 1;
      chk("arm_gate", 32'(GATE), 0);
      chk("arm_valid", 32'(valid), 0);
      for (int i = 0; i < G; i++) begin
         ready = 1'($urandom_range(0, 1));
         tick();
         chk("cnt_gate", 32'(GATE), 1);
         chk("cnt_valid", 32'(valid), 0);
         chk("cnt_bnum", 32'(bnum), last_b);
         chk("cnt_ovf", 32'(OVF), last_o);
      end
      ready = 1'b0;
      tick();
      chk("latch_gate", 32'(GATE), 0);
      chk("latch_valid", 32'(valid), 0);
      expect_of(a, eb, eo);
      tick();
      chk("hold_valid", 32'(valid), 1);
      chk("hold_bnum", 32'(bnum), eb);
      chk("hold_ovf", 32'(OVF), eo);
      chk("hold_gate", 32'(GATE), 0);
      last_b = eb;
      last_o = eo;
      for (int i = 0; i < hold_wait; i++) begin
         tick();
         chk("bp_valid", 32'(valid), 1);
         chk("bp_bnum", 32'(bnum), last_b);
         chk("bp_gate", 32'(GATE), 0);
      end
      ready = 1'b1;
      if (!keep_en) EN = 1'b0;
      tick();
      ready = 1'b0;
      chk("ack_valid", 32'(valid), 0);
      chk("ack_gate", 32'(GATE), 0);
      chk("ack_bnum", 32'(bnum), last_b);
   endtask

   task automatic abort_at(input int at);
      EN = 1'b1;
      tick();
      for (int i = 0; i < at; i++) begin
         tick();
         chk("ab_gate_on", 32'(GATE), 1);
      end
      EN = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("ab_gate", 32'(GATE), 0);
         chk("ab_valid", 32'(valid), 0);
         chk("ab_bnum", 32'(bnum), last_b);
         chk("ab_ovf", 32'(OVF), last_o);
      end
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_bnum", 32'(bnum), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_ovf", 32'(OVF), 0);
      chk("rst_gate", 32'(GATE), 0);
      RST = 1'b0;
      tick();
      chk("idle_hold", 32'(GATE), 0);

      mode = 1; per = 10; pc = 0;
      measure(0, 0, 1);
      measure(1, 0, 0);
      tick();
      chk("idle_after", 32'(GATE), 0);

      mode = 2;
      measure(0, 500, 0);

      mode = 1; per = 2; pc = 0;
      measure(0, 3, 0);

      mode = 1; per = 10;
      measure(0, 0, 0);
      abort_at(50);
      abort_at(0);

      mode = 2;
      EN = 1'b1;
      tick();
      for (int i = 0; i < 60; i++) tick();
      RST = 1'b1;
      tick();
      chk("mid_rst_bnum", 32'(bnum), 0);
      chk("mid_rst_valid", 32'(valid), 0);
      chk("mid_rst_ovf", 32'(OVF), 0);
      chk("mid_rst_gate", 32'(GATE), 0);
      last_b = 0;
      last_o = 0;
      RST = 1'b0;
      tick();
      measure(1, 1, 0);

      mode = 0; hold_v = 1'b1;
      repeat (4) tick();
      measure(0, 0, 0);

      for (int k = 0; k < 6; k++) begin
         mode = 1 + int'($urandom_range(0, 1));
         per = int'($urandom_range(2, 9));
         measure(0, int'($urandom_range(0, 3)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
